// File: rtl/uc_seq.sv
// Sequential control unit for the microc datapath: START bubble, RUN decode, sticky HALT,
// with a saturating retired-instruction counter and a wrapping taken-branch counter.
module uc_seq #(
    parameter int CNT_W = 16,
    parameter int BR_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             pc_hold,
    output logic             halted,
    output logic [CNT_W-1:0] icount,
    output logic [BR_W-1:0]  brcount
);
    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] icount_q, icount_d;
    logic [BR_W-1:0]  brcount_q, brcount_d;
    logic             retire;

    // Outputs default to the idle/bubble word; only RUN overrides them.
    always_comb begin
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we3     = 1'b0;
        wez     = 1'b0;
        Op      = 3'b000;
        pc_hold = 1'b1;
        retire  = 1'b0;
        state_d = state_q;
        case (state_q)
            S_START: state_d = S_RUN;
            S_RUN: begin
                pc_hold = 1'b0;
                retire  = 1'b1;
                casez (Opcode)
                    6'b000???: begin
                        Op  = Opcode[2:0];
                        we3 = 1'b1;
                        wez = 1'b1;
                    end
                    6'b001???: begin
                        we3   = 1'b1;
                        s_inm = 1'b1;
                    end
                    6'b010000: s_inc = 1'b0;
                    6'b010001: s_inc = ~z;
                    6'b010010: s_inc = z;
                    6'b111111: begin
                        pc_hold = 1'b1;
                        retire  = 1'b0;
                        state_d = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_START;
        endcase
    end

    always_comb begin
        icount_d  = icount_q;
        brcount_d = brcount_q;
        if (retire && icount_q != {CNT_W{1'b1}})
            icount_d = icount_q + CNT_W'(1);
        if (state_q == S_RUN && !s_inc)
            brcount_d = brcount_q + BR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_START;
            icount_q  <= '0;
            brcount_q <= '0;
        end else begin
            state_q   <= state_d;
            icount_q  <= icount_d;
            brcount_q <= brcount_d;
        end
    end

    assign halted  = (state_q == S_HALT);
    assign icount  = icount_q;
    assign brcount = brcount_q;
endmodule

// File: doc/uc_seq.md
# uc_seq

Sequential control unit for the single-cycle `microc` datapath. It decodes the 6-bit `Opcode` and the registered zero flag `z` into the datapath control word (`s_inc`, `s_inm`, `we3`, `wez`, `Op`). It adds a start-up bubble, a HALT state, a PC-hold output and retired-instruction/taken-branch counters. `uc_seq` and `microc` are instantiated together in the top-level CPU, with `uc_seq` replacing the stimulus that drove `microc` in unit tests.

## Interface
- `CNT_W`, 16: width of the retired-instruction counter `icount`.
- `BR_W`, 8: width of the taken-branch counter `brcount`.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  reset, synchronous and active-low. It is sampled on the rising edge of `clk`; `reset == 0` at an edge forces the reset state.
- `Opcode`  input  6  instruction opcode from the datapath.
- `z`  input  1  zero flag from the datapath's flag register.
- `s_inc`  output  1  PC source: 1 = PC+1, 0 = jump target.
- `s_inm`  output  1  write-data source: 1 = immediate, 0 = ALU result.
- `we3`  output  1  register-file write enable.
- `wez`  output  1  zero-flag register write enable.
- `Op`  output  3  ALU operation.
- `pc_hold`  output  1  1 = the datapath PC keeps its value this cycle.
- `halted`  output  1  1 while in state HALT.
- `icount`  output  CNT_W  retired instructions, saturating.
- `brcount`  output  BR_W  taken branches, wrapping.

## Operation
- States: START, RUN, HALT. Encoding is free.
- Reset (`reset == 0` at an edge):
  - state = START; `icount` = 0; `brcount` = 0.
  - Reset wins over every other event, including mid-HALT and mid-branch.
- START: one bubble cycle.
  - `s_inc` = 1, `s_inm` = 0, `we3` = 0, `wez` = 0, `Op` = 000, `pc_hold` = 1, `halted` = 0.
  - Next state: RUN.
  - Net effect: the instruction at PC 0 executes in the second cycle after reset deasserts.
- RUN: the control word is combinational from `Opcode` and `z`; `pc_hold` = 0 unless decoding HALT.
  - `000ooo` ALU: `Op` = ooo, `we3` = 1, `wez` = 1, `s_inm` = 0, `s_inc` = 1.
  - `001xxx` LI: `we3` = 1, `s_inm` = 1, `wez` = 0, `Op` = 000, `s_inc` = 1.
  - `010000` J: `s_inc` = 0; no writes.
  - `010001` JZ: `s_inc` = ~z; no writes.
  - `010010` JNZ: `s_inc` = z; no writes.
  - `111111` HALT: no writes, `s_inc` = 1, `pc_hold` = 1; next state HALT.
  - Any other opcode is a NOP: no writes, `s_inc` = 1, `Op` = 000.
- HALT:
  - `halted` = 1, `pc_hold` = 1, all write enables 0, `s_inc` = 1, `Op` = 000.
  - Counters frozen.
  - HALT is left only through reset.
- `icount`: +1 on each RUN edge whose opcode is not HALT. It saturates at all-ones.
- `brcount`: +1 on each RUN edge where the decoded `s_inc` = 0. It wraps modulo 2^BR_W.
- `Opcode` or `z` equal to X/Z in RUN has no defined decode. The bench must never apply it.

## Timing
- Control outputs are Mealy outputs: valid in the same cycle as `Opcode`/`z`.
  - Path: `Opcode`/`z` → outputs is purely combinational.
  - State gates this path; it does not delay it.
- `halted`, `icount` and `brcount` are registered and change only on edges.
- Reset values, from the first edge with `reset == 0` until the first edge with `reset == 1`:
  - Outputs take the START values: `pc_hold` = 1, all enables 0, `Op` = 000, `s_inc` = 1, `halted` = 0, `icount` = 0, `brcount` = 0.
- `z` is the registered flag. A JZ immediately after an ALU op therefore sees the flag written by that ALU op; no extra bubble is inserted.
- HALT decode cycle:
  - `pc_hold` rises combinationally in that cycle.
  - `halted` rises after the next edge.
  - `icount` is not incremented on that edge.
- `icount` at all-ones plus a retiring instruction stays all-ones. `brcount` at all-ones plus a taken branch becomes 0.

## Test plan
- Reset, then a START cycle with `Opcode` = `000010`:
  - During reset and START: `we3` = 0, `pc_hold` = 1.
  - First RUN cycle: `Op` = 010, `we3` = 1, `wez` = 1.
  - After that edge: `icount` = 1.
- LI then ALU: `Opcode` `001000` gives `s_inm` = 1, `we3` = 1, `wez` = 0; next cycle `000011` gives `Op` = 011, `s_inm` = 0.
- Branches with `z` = 0: J gives `s_inc` = 0; JZ gives `s_inc` = 1; JNZ gives `s_inc` = 0. `brcount` goes 0 → 2 after the three edges.
- Branches with `z` = 1: JZ gives `s_inc` = 0, JNZ gives `s_inc` = 1, and `brcount` +1.
- HALT then ALU opcodes:
  - HALT cycle: `pc_hold` = 1, `we3` = 0.
  - After the edge: `halted` = 1.
  - Following `000010` cycles: `we3` = 0, `icount` frozen.
  - `reset` low for one edge: state START, counters 0.
- Counter limits:
  - `CNT_W` = 4: 20 NOPs give `icount` = 15.
  - `BR_W` = 2: 5 taken J give `brcount` = 1.
